// File: rtl/bit_collector_pkg.sv
// Shared types and helpers for the bit_collector serial-to-parallel stage.
package bit_collector_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } collector_state_t;

  // A count of 0..n needs $clog2(n+1) bits, and never fewer than one bit.
  function automatic int cnt_width(int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bit_collector.sv
// Collects COUNT_OF_BITS serial bits into a vector and holds it for the reduction stage.
// Optional registered parity output enabled by the BIT_COLLECTOR_PARITY_EN macro.
module bit_collector
  import bit_collector_pkg::*;
#(
  parameter int COUNT_OF_BITS = 4,
  parameter bit MSB_FIRST     = 1'b0,
  localparam int CNT_W        = cnt_width(COUNT_OF_BITS)
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_bit,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     abort,
  output logic [COUNT_OF_BITS-1:0] out_vector,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         fill_count
`ifdef BIT_COLLECTOR_PARITY_EN
  ,
  output logic                     parity
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT_OF_BITS - 1);

  collector_state_t         r_state;
  collector_state_t         w_nextState;
  logic [CNT_W-1:0]         r_fillCount;
  logic [COUNT_OF_BITS-1:0] r_vector;
  logic [COUNT_OF_BITS-1:0] w_nextVector;
  logic [CNT_W-1:0]         w_bitIndex;
  logic                     w_accept;
  logic                     w_lastBit;
  logic                     w_handshake;

  assign in_ready    = (r_state == COLLECT);
  assign out_valid   = (r_state == HOLD);
  assign out_vector  = r_vector;
  assign fill_count  = r_fillCount;
  assign w_accept    = in_valid && in_ready;
  assign w_lastBit   = (r_fillCount == LAST_IDX);
  assign w_handshake = out_valid && out_ready;
  assign w_bitIndex  = MSB_FIRST ? (LAST_IDX - r_fillCount) : r_fillCount;

  // Only the addressed position changes; the rest keep their previous contents.
  always_comb begin
    w_nextVector = r_vector;
    for (int i = 0; i < COUNT_OF_BITS; i++) begin
      if (CNT_W'(i) == w_bitIndex) begin
        w_nextVector[i] = in_bit;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      COLLECT: if (!abort && w_accept && w_lastBit) w_nextState = HOLD;
      HOLD:    if (abort || out_ready) w_nextState = COLLECT;
      default: w_nextState = COLLECT;
    endcase
  end

  // abort outranks both a bit acceptance and an output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= COLLECT;
      r_fillCount <= '0;
      r_vector    <= '0;
    end else begin
      r_state <= w_nextState;
      if (abort) begin
        r_fillCount <= '0;
      end else if (w_accept) begin
        r_fillCount <= r_fillCount + CNT_W'(1);
        r_vector    <= w_nextVector;
      end else if (w_handshake) begin
        r_fillCount <= '0;
      end
    end
  end

`ifdef BIT_COLLECTOR_PARITY_EN
  logic r_parity;

  assign parity = r_parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (abort || w_handshake) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= r_parity ^ in_bit;
    end
  end
`endif

endmodule

// File: tb/tb_bit_collector.sv
// Scoreboard bench for bit_collector: LSB-first and MSB-first instances share one stimulus stream.
// Parity checks are active when BIT_COLLECTOR_PARITY_EN is defined.
module tb_bit_collector;

  localparam int N     = 4;
  localparam int CNT_W = bit_collector_pkg::cnt_width(N);

  logic clk;
  logic rst;
  logic in_bit;
  logic in_valid;
  logic abort;
  logic out_ready;

  logic [N-1:0]     vecLsb, vecMsb;
  logic             readyLsb, readyMsb;
  logic             validLsb, validMsb;
  logic [CNT_W-1:0] fillLsb, fillMsb;
`ifdef BIT_COLLECTOR_PARITY_EN
  logic             parLsb, parMsb;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N-1:0] lsb;
    logic [N-1:0] msb;
    logic         par;
  } expect_t;

  expect_t sbQ[$];
  bit      modelBits[$];
  bit      modelHolding = 1'b0;
  expect_t newExp;
  expect_t gotExp;

  bit_collector #(.COUNT_OF_BITS(N), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ready(readyLsb),
    .abort(abort), .out_vector(vecLsb), .out_valid(validLsb), .out_ready(out_ready),
    .fill_count(fillLsb)
`ifdef BIT_COLLECTOR_PARITY_EN
    , .parity(parLsb)
`endif
  );

  bit_collector #(.COUNT_OF_BITS(N), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ready(readyMsb),
    .abort(abort), .out_vector(vecMsb), .out_valid(validMsb), .out_ready(out_ready),
    .fill_count(fillMsb)
`ifdef BIT_COLLECTOR_PARITY_EN
    , .parity(parMsb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic b, input logic ab, input logic ordy);
    in_valid  = v;
    in_bit    = b;
    abort     = ab;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a word is the list of accepted bits; once N are gathered it is held until taken.
  always @(posedge clk or posedge rst) begin
    if (rst || abort) begin
      modelBits.delete();
      sbQ.delete();
      modelHolding = 1'b0;
    end else if (modelHolding) begin
      if (out_ready) modelHolding = 1'b0;
    end else if (in_valid) begin
      modelBits.push_back(in_bit);
      if (modelBits.size() == N) begin
        newExp = '0;
        for (int k = 0; k < N; k++) begin
          newExp.lsb[k]     = modelBits[k];
          newExp.msb[N-1-k] = modelBits[k];
          newExp.par        = newExp.par ^ modelBits[k];
        end
        sbQ.push_back(newExp);
        modelBits.delete();
        modelHolding = 1'b1;
      end
    end
  end

  // Monitor: handshake signals every cycle, vectors whenever a word is handed downstream.
  always @(negedge clk) begin
    checkOutput("in_ready_lsb", 32'(readyLsb), 32'(!modelHolding));
    checkOutput("in_ready_msb", 32'(readyMsb), 32'(!modelHolding));
    checkOutput("out_valid_lsb", 32'(validLsb), 32'(modelHolding));
    checkOutput("out_valid_msb", 32'(validMsb), 32'(modelHolding));
    checkOutput("fill_count_lsb", 32'(fillLsb), modelHolding ? 32'(N) : 32'(modelBits.size()));
    checkOutput("fill_count_msb", 32'(fillMsb), modelHolding ? 32'(N) : 32'(modelBits.size()));
    if (!rst && validLsb && out_ready && !abort) begin
      checkOutput("sb_pending", 32'(sbQ.size()), 32'd1);
      if (sbQ.size() > 0) begin
        gotExp = sbQ.pop_front();
        checkOutput("vector_lsb", 32'(vecLsb), 32'(gotExp.lsb));
        checkOutput("vector_msb", 32'(vecMsb), 32'(gotExp.msb));
`ifdef BIT_COLLECTOR_PARITY_EN
        checkOutput("parity_lsb", 32'(parLsb), 32'(gotExp.par));
        checkOutput("parity_msb", 32'(parMsb), 32'(gotExp.par));
`endif
      end
    end
  end

  initial begin
    rst = 1'b0; in_bit = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_in_ready", 32'(readyLsb), 32'd1);
    checkOutput("reset_out_valid", 32'(validLsb), 32'd0);
    checkOutput("reset_vector_lsb", 32'(vecLsb), 32'd0);
    checkOutput("reset_vector_msb", 32'(vecMsb), 32'd0);
    checkOutput("reset_fill", 32'(fillLsb), 32'd0);
`ifdef BIT_COLLECTOR_PARITY_EN
    checkOutput("reset_parity", 32'(parLsb), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 0, 0);
    checkOutput("idle_in_ready", 32'(readyLsb), 32'd1);
    checkOutput("idle_vector", 32'(vecLsb), 32'd0);

    // Stream 1,0,1,1 with downstream stalled.
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("pre_full_valid", 32'(validLsb), 32'd0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("full_valid", 32'(validLsb), 32'd1);
    checkOutput("full_vec_lsb", 32'(vecLsb), 32'b1101);
    checkOutput("full_vec_msb", 32'(vecMsb), 32'b1011);
    checkOutput("full_fill", 32'(fillLsb), 32'(N));
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0, 0);
      checkOutput("stall_vec_lsb", 32'(vecLsb), 32'b1101);
      checkOutput("stall_in_ready", 32'(readyLsb), 32'd0);
    end
    applyStimulus(0, 0, 0, 1);
    checkOutput("after_take_valid", 32'(validLsb), 32'd0);
    checkOutput("after_take_fill", 32'(fillLsb), 32'd0);

    // Abort alongside a third valid bit drops the partial word.
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0);
    checkOutput("abort_fill", 32'(fillLsb), 32'd0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("post_abort_lsb", 32'(vecLsb), 32'b1000);
    checkOutput("post_abort_msb", 32'(vecMsb), 32'b0001);

    // Abort and out_ready together in HOLD: the word is dropped, not transferred.
    applyStimulus(0, 0, 1, 1);
    checkOutput("hold_abort_valid", 32'(validLsb), 32'd0);
    checkOutput("hold_abort_fill", 32'(fillLsb), 32'd0);

    // Asynchronous reset mid-word, between clock edges.
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_fill", 32'(fillLsb), 32'd0);
    checkOutput("midrst_vector", 32'(vecLsb), 32'd0);
    checkOutput("midrst_in_ready", 32'(readyLsb), 32'd1);
    checkOutput("midrst_out_valid", 32'(validLsb), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Stream 1,1,1,0 has odd parity.
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("par_stream_vec", 32'(vecLsb), 32'b0111);
`ifdef BIT_COLLECTOR_PARITY_EN
    checkOutput("par_stream_parity", 32'(parLsb), 32'd1);
`endif
    applyStimulus(0, 0, 0, 1);

    // Randomised traffic; a bit offered while stalled is held until taken.
    for (int c = 0; c < 1500; c++) begin
      if (in_valid && modelHolding) begin
        applyStimulus(in_valid, in_bit, ($urandom_range(0, 99) < 3), ($urandom_range(0, 1) == 1));
      end else begin
        applyStimulus(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 99) < 3),
                      ($urandom_range(0, 1) == 1));
      end
    end
    applyStimulus(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
